// File: rtl/tl_monitor_pkg.sv
// Shared encodings for the traffic-light monitor: phase codes, fault codes,
// lamp patterns, FSM states and dwell-counter commands.
package tl_monitor_pkg;

    localparam logic [1:0] PH_R    = 2'b00;
    localparam logic [1:0] PH_Y    = 2'b01;
    localparam logic [1:0] PH_G    = 2'b10;
    localparam logic [1:0] PH_NONE = 2'b11;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_NOT_ONEHOT = 3'd1;
    localparam logic [2:0] FC_BAD_ORDER  = 3'd2;
    localparam logic [2:0] FC_SHORT      = 3'd3;
    localparam logic [2:0] FC_LONG       = 3'd4;

    // Lamp vectors are packed as {red, yellow, green}.
    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RED,
        ST_YEL,
        ST_GRN,
        ST_FLT
    } state_e;

    typedef enum logic [1:0] {
        DW_HOLD,
        DW_LOAD1,
        DW_INC,
        DW_CLR
    } dwell_cmd_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == LAMP_R) || (v == LAMP_Y) || (v == LAMP_G);
    endfunction

    function automatic state_e lamp_to_state(input logic [2:0] v);
        state_e s;
        case (v)
            LAMP_R:  s = ST_RED;
            LAMP_Y:  s = ST_YEL;
            LAMP_G:  s = ST_GRN;
            default: s = ST_IDLE;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] state_to_lamp(input state_e s);
        logic [2:0] v;
        case (s)
            ST_RED:  v = LAMP_R;
            ST_YEL:  v = LAMP_Y;
            ST_GRN:  v = LAMP_G;
            default: v = LAMP_OFF;
        endcase
        return v;
    endfunction

    function automatic state_e next_legal(input state_e s);
        state_e n;
        case (s)
            ST_RED:  n = ST_YEL;
            ST_YEL:  n = ST_GRN;
            ST_GRN:  n = ST_RED;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tl_dwell_cnt.sv
// Saturating dwell counter: load-1, increment up to sat_lim, hold, or clear.
module tl_dwell_cnt
    import tl_monitor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  dwell_cmd_e       cmd,
    input  logic [CNT_W-1:0] sat_lim,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case (cmd)
            DW_LOAD1: cnt_d = ONE;
            DW_INC: begin
                if (cnt_q < sat_lim) begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DW_CLR:   cnt_d = '0;
            default:  cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tl_monitor.sv
// Traffic-light sequence monitor: checks lamp one-hotness, R->Y->G->R order
// and per-phase dwell limits, latching the first fault until cleared.
module tl_monitor
    import tl_monitor_pkg::*;
#(
    parameter int RG_MIN = 2,
    parameter int RG_MAX = 4,
    parameter int Y_MIN  = 1,
    parameter int Y_MAX  = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             cycle_ok,
    output logic             fault,
    output logic [2:0]       fault_code
);

    localparam logic [CNT_W-1:0] RG_MIN_C = CNT_W'(RG_MIN);
    localparam logic [CNT_W-1:0] RG_MAX_C = CNT_W'(RG_MAX);
    localparam logic [CNT_W-1:0] Y_MIN_C  = CNT_W'(Y_MIN);
    localparam logic [CNT_W-1:0] Y_MAX_C  = CNT_W'(Y_MAX);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [2:0]       lamp_q;
    logic [2:0]       lamp_d;
    state_e           state_q;
    state_e           state_d;
    logic [2:0]       fault_code_q;
    logic [2:0]       fault_code_d;
    logic             cycle_ok_q;
    logic             cycle_ok_d;

    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] cur_min;
    logic [CNT_W-1:0] cur_max;
    logic [CNT_W-1:0] sat_lim;
    dwell_cmd_e       dwell_cmd;
    logic [2:0]       det_code;
    logic             lamp_onehot;
    state_e           lamp_state;

    always_comb begin
        lamp_d = {red, yellow, green};
    end

    always_comb begin
        lamp_onehot = is_onehot3(lamp_q);
        lamp_state  = lamp_to_state(lamp_q);
    end

    // Limits follow the phase currently being timed; yellow has its own window.
    always_comb begin
        if (state_q == ST_YEL) begin
            cur_min = Y_MIN_C;
            cur_max = Y_MAX_C;
        end else begin
            cur_min = RG_MIN_C;
            cur_max = RG_MAX_C;
        end
        sat_lim = cur_max + ONE;
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        cycle_ok_d   = 1'b0;
        dwell_cmd    = DW_HOLD;
        det_code     = FC_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (lamp_q != LAMP_OFF) begin
                    if (lamp_onehot) begin
                        state_d   = lamp_state;
                        dwell_cmd = DW_LOAD1;
                    end else begin
                        det_code = FC_NOT_ONEHOT;
                    end
                end
            end

            ST_RED, ST_YEL, ST_GRN: begin
                // Branch order encodes fault priority.
                if (!lamp_onehot) begin
                    det_code = FC_NOT_ONEHOT;
                end else if (lamp_q == state_to_lamp(state_q)) begin
                    dwell_cmd = DW_INC;
                    if (dwell_cnt >= cur_max) begin
                        det_code = FC_LONG;
                    end
                end else if (lamp_state != next_legal(state_q)) begin
                    det_code = FC_BAD_ORDER;
                end else if (dwell_cnt < cur_min) begin
                    det_code = FC_SHORT;
                end else begin
                    state_d    = lamp_state;
                    dwell_cmd  = DW_LOAD1;
                    cycle_ok_d = (state_q == ST_GRN);
                end
            end

            ST_FLT: begin
                if (clr_fault) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FC_NONE;
                    dwell_cmd    = DW_CLR;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                dwell_cmd = DW_CLR;
            end
        endcase

        // A clear arriving with a fresh fault suppresses it entirely.
        if (det_code != FC_NONE) begin
            if (clr_fault) begin
                state_d      = ST_IDLE;
                fault_code_d = FC_NONE;
                dwell_cmd    = DW_CLR;
            end else begin
                state_d      = ST_FLT;
                fault_code_d = det_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lamp_q       <= LAMP_OFF;
            state_q      <= ST_IDLE;
            fault_code_q <= FC_NONE;
            cycle_ok_q   <= 1'b0;
        end else begin
            lamp_q       <= lamp_d;
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            cycle_ok_q   <= cycle_ok_d;
        end
    end

    tl_dwell_cnt #(
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (dwell_cmd),
        .sat_lim (sat_lim),
        .cnt     (dwell_cnt)
    );

    always_comb begin
        unique case (state_q)
            ST_RED:  phase = PH_R;
            ST_YEL:  phase = PH_Y;
            ST_GRN:  phase = PH_G;
            default: phase = PH_NONE;
        endcase
    end

    assign dwell      = dwell_cnt;
    assign cycle_ok   = cycle_ok_q;
    assign fault      = (state_q == ST_FLT);
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_tl_monitor.sv
// Self-checking bench for tl_monitor: directed vector table, a hand-written
// dwell-limit sequence, and randomized traffic against a reference model.
module tb_tl_monitor;

    localparam int RG_MIN = 2;
    localparam int RG_MAX = 4;
    localparam int Y_MIN  = 1;
    localparam int Y_MAX  = 2;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             red;
    logic             yellow;
    logic             green;
    logic             clr_fault;
    logic [1:0]       phase;
    logic [CNT_W-1:0] dwell;
    logic             cycle_ok;
    logic             fault;
    logic [2:0]       fault_code;

    always #5 clk = ~clk;

    tl_monitor #(
        .RG_MIN (RG_MIN),
        .RG_MAX (RG_MAX),
        .Y_MIN  (Y_MIN),
        .Y_MAX  (Y_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .clr_fault  (clr_fault),
        .phase      (phase),
        .dwell      (dwell),
        .cycle_ok   (cycle_ok),
        .fault      (fault),
        .fault_code (fault_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: phase index -1 idle, 0 red, 1 yellow, 2 green, 3 fault.
    int       m_ph   = -1;
    int       m_cnt  = 0;
    int       m_code = 0;
    bit       m_ok   = 1'b0;
    bit [2:0] m_lamp = 3'b000;

    function automatic int lamp_idx(input bit [2:0] l);
        case (l)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit [2:0] l_in, input bit clr);
        int code;
        int idx;
        int lmin;
        int lmax;
        if (!rst) begin
            m_ph = -1; m_cnt = 0; m_code = 0; m_ok = 1'b0; m_lamp = 3'b000;
            return;
        end
        m_ok = 1'b0;
        code = 0;
        idx  = lamp_idx(m_lamp);
        lmin = (m_ph == 1) ? Y_MIN : RG_MIN;
        lmax = (m_ph == 1) ? Y_MAX : RG_MAX;
        if (m_ph == 3) begin
            if (clr) begin m_ph = -1; m_cnt = 0; m_code = 0; end
        end else begin
            if (m_ph == -1) begin
                if (m_lamp != 3'b000) begin
                    if (idx < 0) code = 1;
                    else begin m_ph = idx; m_cnt = 1; end
                end
            end else if (idx < 0) code = 1;
            else if (idx == m_ph) begin
                m_cnt++;
                if (m_cnt > lmax) code = 4;
            end else if (idx != (m_ph + 1) % 3) code = 2;
            else if (m_cnt < lmin) code = 3;
            else begin
                m_ok = (m_ph == 2);
                m_ph = idx;
                m_cnt = 1;
            end
            if (code != 0) begin
                if (clr) begin m_ph = -1; m_cnt = 0; m_code = 0; end
                else begin m_ph = 3; m_code = code; end
            end
        end
        m_lamp = l_in;
    endtask

    // Drive one cycle, advance the model at the edge, sample 1 time unit later.
    task automatic cyc(input bit r, input bit [2:0] l, input bit c);
        rst_n = r;
        {red, yellow, green} = l;
        clr_fault = c;
        @(posedge clk);
        model_step(r, l, c);
        #1;
    endtask

    typedef struct {
        bit       rst_n;
        bit [2:0] lamps;
        bit       clr;
        int       ph;
        int       dw;
        bit       ok;
        bit       flt;
        int       code;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, input bit [2:0] l, input bit c,
                                input int ph, input int dw, input bit ok,
                                input bit flt, input int code);
        vec_t v;
        v.rst_n = r; v.lamps = l; v.clr = c;
        v.ph = ph; v.dw = dw; v.ok = ok; v.flt = flt; v.code = code;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; red = 1'b0; yellow = 1'b0; green = 1'b0; clr_fault = 1'b0;

        // Normal cycle R x3, Y x2, G x3, R
        vecs.push_back(mk(0, 3'b000, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 1, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 2, 3, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 2, 0, 0, 0));
        // R x3 then G: bad order, then clear
        vecs.push_back(mk(0, 3'b000, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 3, 3, 0, 1, 2));
        vecs.push_back(mk(1, 3'b000, 0, 3, 3, 0, 1, 2));
        vecs.push_back(mk(1, 3'b000, 1, 3, 0, 0, 0, 0));
        // R x1 then Y: short
        vecs.push_back(mk(1, 3'b100, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 3, 1, 0, 1, 3));
        vecs.push_back(mk(1, 3'b000, 1, 3, 0, 0, 0, 0));
        // R held 5 cycles: long, dwell frozen at 5
        vecs.push_back(mk(1, 3'b100, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 4, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 3, 5, 0, 1, 4));
        vecs.push_back(mk(1, 3'b000, 0, 3, 5, 0, 1, 4));
        vecs.push_back(mk(1, 3'b000, 1, 3, 0, 0, 0, 0));
        // R+Y in RED: not one-hot, then clear
        vecs.push_back(mk(1, 3'b100, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b110, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b110, 0, 3, 2, 0, 1, 1));
        vecs.push_back(mk(1, 3'b000, 1, 3, 0, 0, 0, 0));
        // Clear coinciding with a fresh bad-order fault
        vecs.push_back(mk(1, 3'b100, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 3, 0, 0, 0, 0));
        // Clear outside a fault is ignored
        vecs.push_back(mk(1, 3'b100, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 1, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 0, 3, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 0, 1, 1, 0, 0, 0));
        // Reset mid-yellow, then G accepted from idle
        vecs.push_back(mk(0, 3'b010, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 0, 2, 2, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 2, 3, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 0, 3, 3, 0, 1, 1));
        vecs.push_back(mk(1, 3'b000, 1, 3, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst_n, vecs[i].lamps, vecs[i].clr);
            $display("vec %0d: rst_n=%0b lamps=%03b clr=%0b -> phase=%0d dwell=%0d ok=%0b fault=%0b code=%0d",
                     i, vecs[i].rst_n, vecs[i].lamps, vecs[i].clr, phase, dwell, cycle_ok, fault, fault_code);
            chk($sformatf("vec%0d.phase", i), int'(phase), vecs[i].ph);
            chk($sformatf("vec%0d.dwell", i), int'(dwell), vecs[i].dw);
            chk($sformatf("vec%0d.cycle_ok", i), int'(cycle_ok), int'(vecs[i].ok));
            chk($sformatf("vec%0d.fault", i), int'(fault), int'(vecs[i].flt));
            chk($sformatf("vec%0d.code", i), int'(fault_code), vecs[i].code);
        end

        // Hand sequence: red exactly at max is legal, yellow past max is long
        cyc(0, 3'b000, 0);
        cyc(1, 3'b100, 0);
        cyc(1, 3'b100, 0);
        cyc(1, 3'b100, 0);
        cyc(1, 3'b100, 0);
        cyc(1, 3'b010, 0);
        $display("seq red-max: phase=%0d dwell=%0d fault=%0b", phase, dwell, fault);
        chk("seq.red_at_max_dwell", int'(dwell), RG_MAX);
        chk("seq.red_at_max_fault", int'(fault), 0);
        cyc(1, 3'b010, 0);
        $display("seq yel-enter: phase=%0d dwell=%0d fault=%0b", phase, dwell, fault);
        chk("seq.yel_enter_phase", int'(phase), 1);
        chk("seq.yel_enter_fault", int'(fault), 0);
        cyc(1, 3'b010, 0);
        cyc(1, 3'b000, 0);
        $display("seq yel-long: phase=%0d dwell=%0d fault=%0b code=%0d", phase, dwell, fault, fault_code);
        chk("seq.yel_long_code", int'(fault_code), 4);
        chk("seq.yel_long_dwell", int'(dwell), Y_MAX + 1);
        chk("seq.yel_long_phase", int'(phase), 3);

        // Randomized traffic mostly following the legal order with random dwells
        begin
            int       gp;
            int       gleft;
            bit       r;
            bit       c;
            bit [2:0] l;
            int       exp_ph;
            gp = 0;
            gleft = 3;
            cyc(0, 3'b000, 0);
            for (int n = 0; n < 600; n++) begin
                r = ($urandom_range(99) != 0);
                c = ($urandom_range(14) == 0);
                if ($urandom_range(29) == 0) begin
                    l = 3'($urandom_range(7));
                end else begin
                    l = (gp == 0) ? 3'b100 : (gp == 1) ? 3'b010 : 3'b001;
                    gleft--;
                    if (gleft <= 0) begin
                        gp = ($urandom_range(9) == 0) ? int'($urandom_range(2)) : (gp + 1) % 3;
                        gleft = (gp == 1) ? int'($urandom_range(Y_MAX + 1, 1))
                                          : int'($urandom_range(RG_MAX + 1, 1));
                    end
                end
                cyc(r, l, c);
                exp_ph = (m_ph >= 0 && m_ph <= 2) ? m_ph : 3;
                $display("rand %0d: rst_n=%0b lamps=%03b clr=%0b -> phase=%0d dwell=%0d ok=%0b fault=%0b code=%0d",
                         n, r, l, c, phase, dwell, cycle_ok, fault, fault_code);
                chk($sformatf("rand%0d.phase", n), int'(phase), exp_ph);
                chk($sformatf("rand%0d.dwell", n), int'(dwell), m_cnt);
                chk($sformatf("rand%0d.cycle_ok", n), int'(cycle_ok), int'(m_ok));
                chk($sformatf("rand%0d.fault", n), int'(fault), (m_ph == 3) ? 1 : 0);
                chk($sformatf("rand%0d.code", n), int'(fault_code), m_code);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
